// File: rtl/recovery_lock_controller_if.sv
// Control/status bundle between the config side (master) and recovery_lock_controller (slave).
// Widths must match the controller's COUNTER_WIDTH, $clog2(MAX_RETRIES+1) and MODE_WIDTH.
interface recovery_lock_controller_if #(
  parameter int COUNTER_WIDTH = 16,
  parameter int RETRY_WIDTH   = 2,
  parameter int MODE_WIDTH    = 2
);
  // Handshake: there is no valid/ready pair. start, stop and timeout are
  // sampled on every clock edge. primary_edge is a one-cycle pulse. lost is
  // a one-cycle pulse. Every other status output is a registered level.
  logic                     start;
  logic                     stop;
  logic                     cfg_source_select;
  logic [MODE_WIDTH-1:0]    cfg_mode;
  logic [COUNTER_WIDTH-1:0] timeout;
  logic                     primary_edge;

  logic                     recovery_en;
  logic                     source_select;
  logic [MODE_WIDTH-1:0]    recovery_mode;
  logic                     locked;
  logic                     lost;
  logic                     fault;
  logic [COUNTER_WIDTH-1:0] period;
  logic [RETRY_WIDTH-1:0]   retry_cnt;
  logic [2:0]               state_dbg;

  modport master (
    output start, stop, cfg_source_select, cfg_mode, timeout, primary_edge,
    input  recovery_en, source_select, recovery_mode, locked, lost, fault,
           period, retry_cnt, state_dbg
  );

  modport slave (
    input  start, stop, cfg_source_select, cfg_mode, timeout, primary_edge,
    output recovery_en, source_select, recovery_mode, locked, lost, fault,
           period, retry_cnt, state_dbg
  );
endinterface

// File: rtl/recovery_lock_controller.sv
// Sequences a clock-event recovery channel: enable, settle, measure primary-edge
// period, declare lock after consistent periods, retry on loss, sticky fault.
module recovery_lock_controller #(
  parameter int COUNTER_WIDTH = 16,
  parameter int SETTLE_CYCLES = 8,
  parameter int LOCK_COUNT    = 4,
  parameter int TOLERANCE     = 2,
  parameter int MAX_RETRIES   = 3,
  parameter int MODE_WIDTH    = 2
) (
  input logic clk,
  input logic rst,
  recovery_lock_controller_if.slave bus
);
  localparam int RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
  localparam int MW = (LOCK_COUNT > 1) ? $clog2(LOCK_COUNT + 1) : 1;
  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  localparam logic [COUNTER_WIDTH-1:0] CNT_ONE     = COUNTER_WIDTH'(1);
  localparam logic [COUNTER_WIDTH:0]   TOL         = (COUNTER_WIDTH + 1)'(TOLERANCE);
  localparam logic [SW-1:0]            SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [MW-1:0]            MATCH_LAST  = MW'(LOCK_COUNT - 1);
  localparam logic [RW-1:0]            RETRY_MAX   = RW'(MAX_RETRIES);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETTLE  = 3'd1,
    ACQUIRE = 3'd2,
    LOCKED  = 3'd3,
    LOST    = 3'd4
  } state_e;

  state_e                   state;
  logic [SW-1:0]            settle_cnt;
  logic [COUNTER_WIDTH-1:0] cnt;
  logic [COUNTER_WIDTH-1:0] reference;
  logic [MW-1:0]            match_cnt;
  logic                     armed;
  logic                     have_ref;

  logic                     cnt_sat;
  logic [COUNTER_WIDTH:0]   ref_diff;
  logic [COUNTER_WIDTH:0]   per_diff;
  logic                     ref_match;
  logic                     per_match;
  logic                     timed_out;

  assign bus.state_dbg = state;

  // Differences are taken one bit wider so the tolerance compare never wraps.
  always_comb begin
    cnt_sat   = &cnt;
    ref_diff  = (cnt >= reference) ? ({1'b0, cnt} - {1'b0, reference})
                                   : ({1'b0, reference} - {1'b0, cnt});
    per_diff  = (cnt >= bus.period) ? ({1'b0, cnt} - {1'b0, bus.period})
                                    : ({1'b0, bus.period} - {1'b0, cnt});
    ref_match = !cnt_sat && (ref_diff <= TOL);
    per_match = !cnt_sat && (per_diff <= TOL);
    timed_out = (bus.timeout != '0) && (cnt >= bus.timeout);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      settle_cnt        <= '0;
      cnt               <= '0;
      reference         <= '0;
      match_cnt         <= '0;
      armed             <= 1'b0;
      have_ref          <= 1'b0;
      bus.recovery_en   <= 1'b0;
      bus.source_select <= 1'b0;
      bus.recovery_mode <= '0;
      bus.locked        <= 1'b0;
      bus.lost          <= 1'b0;
      bus.fault         <= 1'b0;
      bus.period        <= '0;
      bus.retry_cnt     <= '0;
    end else begin
      bus.lost <= 1'b0;
      if (bus.stop) begin
        state           <= IDLE;
        bus.recovery_en <= 1'b0;
        bus.locked      <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            bus.recovery_en <= 1'b0;
            bus.locked      <= 1'b0;
            if (bus.start) begin
              bus.source_select <= bus.cfg_source_select;
              bus.recovery_mode <= bus.cfg_mode;
              bus.fault         <= 1'b0;
              bus.retry_cnt     <= '0;
              settle_cnt        <= '0;
              bus.recovery_en   <= 1'b1;
              state             <= SETTLE;
            end
          end

          SETTLE: begin
            if (settle_cnt == SETTLE_LAST) begin
              state     <= ACQUIRE;
              cnt       <= CNT_ONE;
              armed     <= 1'b0;
              have_ref  <= 1'b0;
              match_cnt <= '0;
            end else begin
              settle_cnt <= settle_cnt + SW'(1);
            end
          end

          ACQUIRE: begin
            if (bus.primary_edge) begin
              cnt <= CNT_ONE;
              if (!armed) begin
                armed <= 1'b1;
              end else if (!have_ref) begin
                reference <= cnt;
                have_ref  <= 1'b1;
                match_cnt <= '0;
              end else if (ref_match) begin
                if (match_cnt == MATCH_LAST) begin
                  state         <= LOCKED;
                  bus.locked    <= 1'b1;
                  bus.period    <= reference;
                  bus.retry_cnt <= '0;
                end else begin
                  match_cnt <= match_cnt + MW'(1);
                end
              end else begin
                reference <= cnt;
                match_cnt <= '0;
              end
            end else if (timed_out) begin
              state           <= LOST;
              bus.lost        <= 1'b1;
              bus.recovery_en <= 1'b0;
              bus.locked      <= 1'b0;
            end else if (!cnt_sat) begin
              cnt <= cnt + CNT_ONE;
            end
          end

          LOCKED: begin
            if (bus.primary_edge && per_match) begin
              cnt <= CNT_ONE;
            end else if (bus.primary_edge || timed_out) begin
              state           <= LOST;
              bus.lost        <= 1'b1;
              bus.recovery_en <= 1'b0;
              bus.locked      <= 1'b0;
            end else if (!cnt_sat) begin
              cnt <= cnt + CNT_ONE;
            end
          end

          LOST: begin
            if (bus.retry_cnt < RETRY_MAX) begin
              bus.retry_cnt   <= bus.retry_cnt + RW'(1);
              settle_cnt      <= '0;
              bus.recovery_en <= 1'b1;
              state           <= SETTLE;
            end else begin
              bus.fault <= 1'b1;
              state     <= IDLE;
            end
          end

          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule
